// File: rtl/stream_downsizer.sv
// Wide-to-narrow valid/ready stage: splits each IN_WIDTH word into RATIO beats,
// least-significant slice first, and flags the final beat of every word.
module stream_downsizer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 arst_n,
    input  logic [IN_WIDTH-1:0]  data_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 data_out_valid,
    output logic                 data_out_last,
    input  logic                 data_out_ready
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IN_WIDTH-1:0] buf_q, buf_d;
    logic                full_q;
    logic                is_last;
    logic                in_hs;
    logic                out_hs;

    assign full_q  = (state_q == BUSY);
    assign is_last = (idx_q == LAST_IDX);
    assign out_hs  = full_q && data_out_ready;
    assign in_hs   = data_in_valid && data_in_ready;

    always_ff @(posedge clk_i or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

    // A load always takes priority, which lets a new word replace the last beat
    // of the previous one in the same cycle without a bubble.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        if (in_hs) begin
            state_d = BUSY;
            idx_d   = '0;
            buf_d   = data_in;
        end else if (out_hs) begin
            if (is_last) begin
                state_d = EMPTY;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // data_in_ready depends combinationally on data_out_ready for word chaining.
    always_comb begin
        data_out = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (idx_q == IDX_W'(i)) begin
                data_out = buf_q[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
        data_out_valid = full_q;
        data_out_last  = full_q && is_last;
        data_in_ready  = !full_q || (data_out_last && data_out_ready);
    end

endmodule

// File: tb/tb_stream_downsizer.sv
// Self-checking bench for stream_downsizer: directed word sequences plus a random
// soak, compared every cycle against a byte-queue model of the stream.
module tb_stream_downsizer;

    localparam int IN_WIDTH  = 32;
    localparam int OUT_WIDTH = 8;
    localparam int RATIO     = IN_WIDTH / OUT_WIDTH;
    localparam int SOAK_WORDS = 200;

    logic                 clk_i = 1'b0;
    logic                 arst_n;
    logic [IN_WIDTH-1:0]  data_in;
    logic                 data_in_valid;
    logic                 data_in_ready;
    logic [OUT_WIDTH-1:0] data_out;
    logic                 data_out_valid;
    logic                 data_out_last;
    logic                 data_out_ready;

    int errors = 0;
    int checks = 0;
    int beats_out = 0;
    logic [OUT_WIDTH-1:0] model_q[$];

    stream_downsizer #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .clk_i         (clk_i),
        .arst_n        (arst_n),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_last (data_out_last),
        .data_out_ready(data_out_ready)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [IN_WIDTH-1:0] d, input logic r);
        data_in_valid  = v;
        data_in        = d;
        data_out_ready = r;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkBeat(input string tag, input logic [7:0] d, input logic last, input logic rdy);
        #1;
        checkOutput({tag, "_valid"}, data_out_valid, 1'b1);
        checkOutput({tag, "_data"}, data_out, d);
        checkOutput({tag, "_last"}, data_out_last, last);
        checkOutput({tag, "_in_ready"}, data_in_ready, rdy);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, data_out_valid, 1'b0);
        checkOutput({tag, "_last"}, data_out_last, 1'b0);
        checkOutput({tag, "_in_ready"}, data_in_ready, 1'b1);
        checkOutput({tag, "_data"}, data_out, 8'h00);
    endtask

    // Stream model: the bytes still owed for the current word, oldest first.
    always @(posedge clk_i or negedge arst_n) begin
        logic pop;
        logic acc;
        if (!arst_n) begin
            model_q.delete();
        end else begin
            pop = (model_q.size() > 0) && data_out_ready;
            acc = data_in_valid && ((model_q.size() == 0) || ((model_q.size() == 1) && data_out_ready));
            if (pop) begin
                void'(model_q.pop_front());
                beats_out++;
            end
            if (acc) begin
                for (int i = 0; i < RATIO; i++) begin
                    model_q.push_back(data_in[i*OUT_WIDTH +: OUT_WIDTH]);
                end
            end
        end
    end

    always @(negedge clk_i) begin
        logic exp_valid;
        logic exp_last;
        logic exp_rdy;
        exp_valid = (model_q.size() > 0);
        exp_last  = (model_q.size() == 1);
        exp_rdy   = (model_q.size() == 0) || ((model_q.size() == 1) && data_out_ready);
        checkOutput("model_valid", data_out_valid, exp_valid);
        checkOutput("model_last", data_out_last, exp_last);
        checkOutput("model_in_ready", data_in_ready, exp_rdy);
        if (exp_valid) begin
            checkOutput("model_data", data_out, model_q[0]);
        end
    end

    initial begin
        logic [7:0] sw [4];
        logic [7:0] rw [4];
        logic hs;
        int sent;
        int cyc;

        sw = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        rw = '{8'h88, 8'h77, 8'h66, 8'h55};

        arst_n = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        #2;
        checkResetOutputs("por");
        #10;
        arst_n = 1'b1;
        step();

        $display("[TB] single word");
        applyStimulus(1'b1, 32'hAABBCCDD, 1'b1);
        #1;
        checkOutput("idle_in_ready", data_in_ready, 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkBeat("single", sw[i], i == 3, i == 3);
            step();
        end
        checkOutput("single_drained", data_out_valid, 1'b0);

        $display("[TB] back-to-back");
        applyStimulus(1'b1, 32'h03020100, 1'b1);
        step();
        data_in = 32'h07060504;
        for (int i = 0; i < 8; i++) begin
            checkBeat("b2b", 8'(i), (i % 4) == 3, (i % 4) == 3);
            step();
            if (i == 3) data_in_valid = 1'b0;
        end
        checkOutput("b2b_drained", data_out_valid, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'h11223344, 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b1);
        checkBeat("bp", 8'h44, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'h99AABBCC, 1'b0);
        repeat (3) begin
            checkBeat("bp_hold", 8'h33, 1'b0, 1'b0);
            step();
        end
        data_out_ready = 1'b1;
        checkBeat("bp", 8'h33, 1'b0, 1'b0);
        step();
        checkBeat("bp", 8'h22, 1'b0, 1'b0);
        step();
        checkBeat("bp", 8'h11, 1'b1, 1'b1);
        step();
        data_in_valid = 1'b0;
        checkBeat("bp_next", 8'hCC, 1'b0, 1'b0);
        step();
        checkBeat("bp_next", 8'hBB, 1'b0, 1'b0);
        step();
        checkBeat("bp_next", 8'hAA, 1'b0, 1'b0);
        step();
        checkBeat("bp_next", 8'h99, 1'b1, 1'b1);
        step();
        checkOutput("bp_drained", data_out_valid, 1'b0);

        $display("[TB] mid-word reset");
        applyStimulus(1'b1, 32'hAABBCCDD, 1'b1);
        step();
        data_in_valid = 1'b0;
        checkBeat("mid", 8'hDD, 1'b0, 1'b0);
        step();
        checkBeat("mid", 8'hCC, 1'b0, 1'b0);
        #2;
        arst_n = 1'b0;
        #1;
        checkResetOutputs("async_rst");
        @(negedge clk_i);
        #2;
        arst_n = 1'b1;
        step();
        applyStimulus(1'b1, 32'h55667788, 1'b1);
        step();
        data_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkBeat("post_rst", rw[i], i == 3, i == 3);
            step();
        end
        checkOutput("post_rst_drained", data_out_valid, 1'b0);

        $display("[TB] random soak");
        beats_out = 0;
        sent = 0;
        cyc = 0;
        hs = 1'b0;
        data_in_valid = 1'b0;
        while (sent < SOAK_WORDS && cyc < 30000) begin
            @(posedge clk_i);
            #1;
            cyc++;
            if (hs) sent++;
            data_out_ready = ($urandom_range(0, 5) == 0);
            if (sent >= SOAK_WORDS) begin
                data_in_valid = 1'b0;
            end else if (!data_in_valid || hs) begin
                data_in_valid = 1'($urandom_range(0, 1));
                data_in = $urandom();
            end
            @(negedge clk_i);
            hs = data_in_valid && data_in_ready;
        end
        checkOutput("soak_in_time", cyc < 30000, 1'b1);
        data_in_valid = 1'b0;
        data_out_ready = 1'b1;
        cyc = 0;
        while (model_q.size() > 0 && cyc < 50) begin
            step();
            cyc++;
        end
        #1;
        checkOutput("soak_drain", model_q.size(), 0);
        checkOutput("soak_beats", beats_out, SOAK_WORDS * RATIO);
        checkOutput("soak_idle", data_out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
